rs_dispatch_credit_gen: RTL and testbench

//  Parametrised dispatch-side request generator for the reservation stations (RS).

---
 rtl/rs_pkg.sv | 16 +
 rtl/rs_credit_ctr.sv | 32 +++
 rtl/rs_dispatch_credit_gen.sv | 147 ++++++++++++++
 tb/tb_rs_dispatch_credit_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared reservation-station class codes and defaults
package rs_pkg;

   localparam int RS_ENT_SEL    = 3;
   localparam int RS_DEPTH_DFLT = 8;

   // Code 0 means the instruction needs no RS entry; class index is code-1.
   typedef enum logic [RS_ENT_SEL-1:0] {
      RS_CLS_NONE   = 3'd0,
      RS_CLS_ALU    = 3'd1,
      RS_CLS_BRANCH = 3'd2,
      RS_CLS_MUL    = 3'd3,
      RS_CLS_LDST   = 3'd4
   } rs_cls_e;

endpackage

// File: rtl/rs_credit_ctr.sv
// rtl/rs_credit_ctr.sv - free-entry credit counter for one RS class
module rs_credit_ctr #(
   parameter int RS_DEPTH = 8,
   parameter int CRD_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [CRD_W-1:0] dec,
   input  logic [CRD_W-1:0] inc,
   output logic [CRD_W-1:0] credit,
   output logic             overflow
);

   localparam logic [CRD_W:0] DEPTH_V = (CRD_W+1)'(RS_DEPTH);

   logic [CRD_W:0] sum;

   // dec never exceeds credit, so the extra top bit only ever carries a release overshoot.
   assign sum      = {1'b0, credit} + {1'b0, inc} - {1'b0, dec};
   assign overflow = ~flush & (sum > DEPTH_V);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         credit <= DEPTH_V[CRD_W-1:0];
      else if (flush || overflow)
         credit <= DEPTH_V[CRD_W-1:0];
      else
         credit <= sum[CRD_W-1:0];
   end

endmodule

// File: rtl/rs_dispatch_credit_gen.sv
// rtl/rs_dispatch_credit_gen.sv - RS request decode, in-order credit grant and stall; RS_DISP_STATS_EN adds stall_cyc
module rs_dispatch_credit_gen
   import rs_pkg::*;
#(
   parameter int DISP_W   = 2,
   parameter int NUM_CLS  = 4,
   parameter int ENT_SEL  = RS_ENT_SEL,
   parameter int RS_DEPTH = RS_DEPTH_DFLT,
   parameter int CRD_W    = 4,
   parameter int PARTIAL  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DISP_W-1:0]          slot_valid,
   input  logic [DISP_W*ENT_SEL-1:0]  slot_cls,
   input  logic                       disp_en,
   input  logic                       flush,
   input  logic [NUM_CLS*CRD_W-1:0]   rel_cnt,
   output logic [NUM_CLS*DISP_W-1:0]  req,
   output logic [NUM_CLS*2-1:0]       req_num,
   output logic [DISP_W-1:0]          grant,
   output logic                       stall,
   output logic [NUM_CLS*CRD_W-1:0]   credit,
   output logic                       credit_err
`ifdef RS_DISP_STATS_EN
   ,
   output logic [NUM_CLS*32-1:0]      stall_cyc
`endif
);

   logic [DISP_W-1:0][NUM_CLS-1:0] hit;
   logic [NUM_CLS-1:0][CRD_W-1:0]  crd;
   logic [NUM_CLS-1:0][CRD_W-1:0]  cnt;
   logic [NUM_CLS-1:0][CRD_W-1:0]  dec;
   logic [NUM_CLS-1:0]             ovf;
   logic [DISP_W-1:0]              elig;
   logic                           ok;
   logic                           run;
   logic                           all_ok;
`ifdef RS_DISP_STATS_EN
   logic [DISP_W-1:0]              short;
`endif

   always_comb begin
      hit     = '0;
      req     = '0;
      req_num = '0;
      cnt     = '0;
      dec     = '0;
      elig    = '0;
      grant   = '0;
      ok      = 1'b0;
      run     = 1'b1;
      all_ok  = 1'b1;
`ifdef RS_DISP_STATS_EN
      short   = '0;
`endif
      for (int s = 0; s < DISP_W; s++) begin
         ok = slot_valid[s] & disp_en & ~flush & ~reset;
         for (int c = 0; c < NUM_CLS; c++) begin
            hit[s][c] = slot_valid[s] && (slot_cls[s*ENT_SEL +: ENT_SEL] == ENT_SEL'(c+1));
            req[c*DISP_W+s] = hit[s][c];
            if (hit[s][c]) begin
               // cnt counts lower valid slots of this class: the grants this slot must queue behind
               if (crd[c] <= cnt[c]) begin
                  ok = 1'b0;
`ifdef RS_DISP_STATS_EN
                  short[s] = 1'b1;
`endif
               end
               cnt[c] = cnt[c] + 1'b1;
               req_num[c*2 +: 2] = req_num[c*2 +: 2] + 2'd1;
            end
         end
         elig[s] = ok;
         all_ok  = all_ok & (~slot_valid[s] | ok);
      end
      if (PARTIAL != 0) begin
         for (int s = 0; s < DISP_W; s++) begin
            grant[s] = elig[s] & run;
            run      = run & (~slot_valid[s] | elig[s]);
         end
      end else begin
         grant = slot_valid & {DISP_W{all_ok}};
      end
      for (int s = 0; s < DISP_W; s++)
         for (int c = 0; c < NUM_CLS; c++)
            if (grant[s] && hit[s][c])
               dec[c] = dec[c] + 1'b1;
   end

   assign stall  = |(slot_valid & ~grant);
   assign credit = crd;

   for (genvar c = 0; c < NUM_CLS; c++) begin : g_ctr
      rs_credit_ctr #(
         .RS_DEPTH (RS_DEPTH),
         .CRD_W    (CRD_W)
      ) u_ctr (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .dec      (dec[c]),
         .inc      (rel_cnt[c*CRD_W +: CRD_W]),
         .credit   (crd[c]),
         .overflow (ovf[c])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         credit_err <= 1'b0;
      else if (|ovf)
         credit_err <= 1'b1;
   end

`ifdef RS_DISP_STATS_EN
   logic [NUM_CLS-1:0]       stat_hit;
   logic                     found;
   logic [NUM_CLS-1:0][31:0] stat;

   // Only the oldest blocked slot is charged, and only when its class ran out of credit.
   always_comb begin
      stat_hit = '0;
      found    = 1'b0;
      for (int s = 0; s < DISP_W; s++) begin
         if (!found && slot_valid[s] && !grant[s]) begin
            found = 1'b1;
            if (short[s])
               stat_hit = hit[s];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stat <= '0;
      else
         for (int c = 0; c < NUM_CLS; c++)
            if (stat_hit[c] && stat[c] != 32'hFFFF_FFFF)
               stat[c] <= stat[c] + 32'd1;
   end

   assign stall_cyc = stat;
`endif

endmodule

// File: tb/tb_rs_dispatch_credit_gen.sv
// tb/tb_rs_dispatch_credit_gen.sv - scoreboard bench: partial and all-or-nothing instances on shared stimulus
module tb_rs_dispatch_credit_gen;
   import rs_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  slot_valid = '0;
   logic [5:0]  slot_cls = '0;
   logic        disp_en = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] rel_cnt = '0;

   logic [7:0]  req_a, req_b, req_num_a, req_num_b;
   logic [1:0]  grant_a, grant_b;
   logic        stall_a, stall_b, err_a, err_b;
   logic [15:0] credit_a, credit_b;
`ifdef RS_DISP_STATS_EN
   logic [127:0] stall_cyc_a, stall_cyc_b;
`endif

   always #5 clk = ~clk;

   rs_dispatch_credit_gen #(.PARTIAL(1)) dut_a (
      .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot_cls(slot_cls),
      .disp_en(disp_en), .flush(flush), .rel_cnt(rel_cnt), .req(req_a),
      .req_num(req_num_a), .grant(grant_a), .stall(stall_a), .credit(credit_a),
      .credit_err(err_a)
`ifdef RS_DISP_STATS_EN
      , .stall_cyc(stall_cyc_a)
`endif
   );

   rs_dispatch_credit_gen #(.PARTIAL(0)) dut_b (
      .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot_cls(slot_cls),
      .disp_en(disp_en), .flush(flush), .rel_cnt(rel_cnt), .req(req_b),
      .req_num(req_num_b), .grant(grant_b), .stall(stall_b), .credit(credit_b),
      .credit_err(err_b)
`ifdef RS_DISP_STATS_EN
      , .stall_cyc(stall_cyc_b)
`endif
   );

   typedef struct {
      string       tag;
      logic [1:0]  ga;
      logic        sa;
      logic [1:0]  gb;
      logic        sb;
      logic [7:0]  rn;
      logic [15:0] ca;
      logic [15:0] cb;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] cv(input int alu, input int br, input int mul, input int ld);
      return {4'(ld), 4'(mul), 4'(br), 4'(alu)};
   endfunction

   function automatic exp_t mk(input string tag, input logic [1:0] ga, input logic sa,
                               input logic [1:0] gb, input logic sb, input logic [7:0] rn,
                               input logic [15:0] ca, input logic [15:0] cb, input logic err);
      exp_t e;
      e.tag = tag; e.ga = ga; e.sa = sa; e.gb = gb; e.sb = sb;
      e.rn = rn; e.ca = ca; e.cb = cb; e.err = err;
      return e;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
   task automatic cyc(input logic r, input logic [1:0] v, input logic [2:0] c0, input logic [2:0] c1,
                      input logic en, input logic fl, input logic [15:0] rel, input exp_t e);
      exp_t o;
      @(posedge clk);
      #1;
      reset = r; slot_valid = v; slot_cls = {c1, c0}; disp_en = en; flush = fl; rel_cnt = rel;
      sb_q.push_back(e);
      @(negedge clk);
      o = sb_q.pop_front();
      chk({o.tag, "/grant_a"},  32'(grant_a),   32'(o.ga));
      chk({o.tag, "/stall_a"},  32'(stall_a),   32'(o.sa));
      chk({o.tag, "/grant_b"},  32'(grant_b),   32'(o.gb));
      chk({o.tag, "/stall_b"},  32'(stall_b),   32'(o.sb));
      chk({o.tag, "/req_num"},  32'(req_num_a), 32'(o.rn));
      chk({o.tag, "/credit_a"}, 32'(credit_a),  32'(o.ca));
      chk({o.tag, "/credit_b"}, 32'(credit_b),  32'(o.cb));
      chk({o.tag, "/err_a"},    32'(err_a),     32'(o.err));
      chk({o.tag, "/err_b"},    32'(err_b),     32'(o.err));
   endtask

   localparam logic [2:0] NO = RS_CLS_NONE;
   localparam logic [2:0] AL = RS_CLS_ALU;
   localparam logic [2:0] MU = RS_CLS_MUL;
   localparam logic [2:0] LD = RS_CLS_LDST;

   initial begin
      logic [15:0] full;
      full = cv(8, 8, 8, 8);
      cyc(1, 2'b11, AL, AL, 1, 0, 16'h0, mk("rst",    2'b00, 1, 2'b00, 1, 8'h02, full, full, 0));
      cyc(0, 2'b11, AL, AL, 1, 0, 16'h0, mk("alu2",   2'b11, 0, 2'b11, 0, 8'h02, full, full, 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("idle1",  2'b00, 0, 2'b00, 0, 8'h00, cv(6,8,8,8), cv(6,8,8,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("mul8",   2'b11, 0, 2'b11, 0, 8'h20, cv(6,8,8,8), cv(6,8,8,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("mul6",   2'b11, 0, 2'b11, 0, 8'h20, cv(6,8,6,8), cv(6,8,6,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("mul4",   2'b11, 0, 2'b11, 0, 8'h20, cv(6,8,4,8), cv(6,8,4,8), 0));
      cyc(0, 2'b01, MU, NO, 1, 0, 16'h0, mk("mul2",   2'b01, 0, 2'b01, 0, 8'h10, cv(6,8,2,8), cv(6,8,2,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("mul1",   2'b01, 1, 2'b00, 1, 8'h20, cv(6,8,1,8), cv(6,8,1,8), 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("idle2",  2'b00, 0, 2'b00, 0, 8'h00, cv(6,8,0,8), cv(6,8,1,8), 0));
      cyc(0, 2'b11, LD, LD, 1, 0, 16'h0, mk("ld8",    2'b11, 0, 2'b11, 0, 8'h80, cv(6,8,0,8), cv(6,8,1,8), 0));
      cyc(0, 2'b11, LD, LD, 1, 0, 16'h0, mk("ld6",    2'b11, 0, 2'b11, 0, 8'h80, cv(6,8,0,6), cv(6,8,1,6), 0));
      cyc(0, 2'b11, LD, LD, 1, 0, 16'h0, mk("ld4",    2'b11, 0, 2'b11, 0, 8'h80, cv(6,8,0,4), cv(6,8,1,4), 0));
      cyc(0, 2'b11, LD, LD, 1, 0, 16'h0, mk("ld2",    2'b11, 0, 2'b11, 0, 8'h80, cv(6,8,0,2), cv(6,8,1,2), 0));
      cyc(0, 2'b01, LD, NO, 1, 0, 16'h2000, mk("ld0rel", 2'b00, 1, 2'b00, 1, 8'h40, cv(6,8,0,0), cv(6,8,1,0), 0));
      cyc(0, 2'b01, LD, NO, 1, 0, 16'h0, mk("ldnext", 2'b01, 0, 2'b01, 0, 8'h40, cv(6,8,0,2), cv(6,8,1,2), 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("idle3",  2'b00, 0, 2'b00, 0, 8'h00, cv(6,8,0,1), cv(6,8,1,1), 0));
      cyc(0, 2'b11, AL, AL, 1, 0, 16'h0, mk("alu6",   2'b11, 0, 2'b11, 0, 8'h02, cv(6,8,0,1), cv(6,8,1,1), 0));
      cyc(0, 2'b01, AL, NO, 1, 0, 16'h0, mk("alu4",   2'b01, 0, 2'b01, 0, 8'h01, cv(4,8,0,1), cv(4,8,1,1), 0));
      cyc(0, 2'b01, AL, NO, 1, 1, 16'h0001, mk("flush", 2'b00, 1, 2'b00, 1, 8'h01, cv(3,8,0,1), cv(3,8,1,1), 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("postfl", 2'b00, 0, 2'b00, 0, 8'h00, full, full, 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0010, mk("brovf", 2'b00, 0, 2'b00, 0, 8'h00, full, full, 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("errset", 2'b00, 0, 2'b00, 0, 8'h00, full, full, 1));
      cyc(0, 2'b00, NO, NO, 1, 1, 16'h0, mk("errfl",  2'b00, 0, 2'b00, 0, 8'h00, full, full, 1));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("errkeep", 2'b00, 0, 2'b00, 0, 8'h00, full, full, 1));
      cyc(0, 2'b11, AL, AL, 0, 0, 16'h0, mk("noen",   2'b00, 1, 2'b00, 1, 8'h02, full, full, 1));
      cyc(0, 2'b10, MU, AL, 1, 0, 16'h0, mk("hole",   2'b10, 0, 2'b10, 0, 8'h01, full, full, 1));
      cyc(0, 2'b01, 3'd7, NO, 1, 0, 16'h0, mk("badcode", 2'b01, 0, 2'b01, 0, 8'h00, cv(7,8,8,8), cv(7,8,8,8), 1));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("idle4",  2'b00, 0, 2'b00, 0, 8'h00, cv(7,8,8,8), cv(7,8,8,8), 1));
      cyc(1, 2'b00, NO, NO, 1, 0, 16'h0, mk("rst2",   2'b00, 0, 2'b00, 0, 8'h00, full, full, 0));
`ifdef RS_DISP_STATS_EN
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("s_mul8", 2'b11, 0, 2'b11, 0, 8'h20, full, full, 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("s_mul6", 2'b11, 0, 2'b11, 0, 8'h20, cv(8,8,6,8), cv(8,8,6,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("s_mul4", 2'b11, 0, 2'b11, 0, 8'h20, cv(8,8,4,8), cv(8,8,4,8), 0));
      cyc(0, 2'b11, MU, MU, 1, 0, 16'h0, mk("s_mul2", 2'b11, 0, 2'b11, 0, 8'h20, cv(8,8,2,8), cv(8,8,2,8), 0));
      for (int i = 0; i < 5; i++)
         cyc(0, 2'b01, MU, NO, 1, 0, 16'h0, mk("s_hold", 2'b00, 1, 2'b00, 1, 8'h10, cv(8,8,0,8), cv(8,8,0,8), 0));
      cyc(0, 2'b00, NO, NO, 1, 0, 16'h0, mk("s_idle", 2'b00, 0, 2'b00, 0, 8'h00, cv(8,8,0,8), cv(8,8,0,8), 0));
      chk("stall_cyc_mul", stall_cyc_a[2*32 +: 32], 32'd5);
      chk("stall_cyc_alu", stall_cyc_a[0 +: 32], 32'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
